// File: rtl/edge_run_meter_pkg.sv
// Shared types and helpers for the edge run-length meter.
package edge_run_meter_pkg;

  typedef enum logic [1:0] {PRIME, SYNC, MEASURE} meter_state_t;

  localparam int CNT_W_DEFAULT = 32;
  localparam int SAT_MAX_W     = 64;

  // Saturating increment for a counter of width w (w <= SAT_MAX_W), carried in a wide container.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] cnt, input int w);
    logic [SAT_MAX_W-1:0] ones;
    ones = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - w);
    return (cnt >= ones) ? ones : cnt + {{(SAT_MAX_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/edge_run_meter_sync_edge_detect.sv
// Holds the previous level and a primed flag; flags a level change once primed.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic in_1,
  output logic edge_det,
  output logic prev_level
);

  logic primed;

  always_ff @(posedge clk) begin
    if (rst) begin
      primed     <= 1'b0;
      prev_level <= 1'b0;
    end else begin
      primed     <= 1'b1;
      prev_level <= in_1;
    end
  end

  assign edge_det = primed && (in_1 != prev_level);

endmodule

// File: rtl/edge_run_meter.sv
// Measures run lengths between level edges and publishes {level, length} through a one-entry slot.
// Optional min/max run statistics are enabled with EDGE_RUN_METER_STATS_EN.
module edge_run_meter
  import edge_run_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_1,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] m_len,
  output logic             m_level,
  output logic             overrun,
  input  logic             clr_overrun
`ifdef EDGE_RUN_METER_STATS_EN
  ,
  output logic [CNT_W-1:0] min_len,
  output logic [CNT_W-1:0] max_len
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  meter_state_t         state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [SAT_MAX_W-1:0] cnt_wide;
  logic                 edge_det, prev_level, publish;

  sync_edge_detect u_sync_edge_detect (
    .clk        (clk),
    .rst        (rst),
    .in_1       (in_1),
    .edge_det   (edge_det),
    .prev_level (prev_level)
  );

  assign cnt_wide = sat_inc(SAT_MAX_W'(cnt_q), CNT_W);
  assign cnt_inc  = cnt_wide[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PRIME;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    publish = 1'b0;
    case (state_q)
      PRIME:   state_d = SYNC;
      SYNC: begin
        // The run in progress at start-up has no known start, so it only arms the counter.
        if (edge_det) begin
          cnt_d   = CNT_ONE;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (edge_det) begin
          publish = 1'b1;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = cnt_inc;
        end
      end
      default: state_d = PRIME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_len   <= '0;
      m_level <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (publish && (!m_valid || m_ready)) begin
        m_valid <= 1'b1;
        m_len   <= cnt_q;
        m_level <= prev_level;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      // A drop in the same cycle as a clear request keeps the flag set.
      if (publish && m_valid && !m_ready) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef EDGE_RUN_METER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      min_len <= '1;
      max_len <= '0;
    end else if (publish) begin
      if (cnt_q < min_len) min_len <= cnt_q;
      if (cnt_q > max_len) max_len <= cnt_q;
    end
  end
`endif

endmodule
